// File: rtl/pn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pn_pkg                                                   |
// | Description : Shared definitions for the PN sequence generator:        |
// |               controller state encoding and a table of default         |
// |               maximal-length feedback tap masks for WIDTH 3..16.       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package pn_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_RUN  = 2'b01
  } pn_state_e;

  // Tap masks for the right-shifting form used by pn_seq_gen: bit i set
  // means state bit i feeds the XOR whose result enters the MSB. Each mask
  // always contains bit 0, so the recurrence is s[t+n] = s[t] ^ (others).
  function automatic logic [15:0] pn_default_taps(input int width);
    logic [15:0] taps;
    case (width)
      3:       taps = 16'h0003;
      4:       taps = 16'h0009;
      5:       taps = 16'h0005;
      6:       taps = 16'h0003;
      7:       taps = 16'h0003;
      8:       taps = 16'h0071;
      9:       taps = 16'h0011;
      10:      taps = 16'h0009;
      11:      taps = 16'h0005;
      12:      taps = 16'h0053;
      13:      taps = 16'h001B;
      14:      taps = 16'h0443;
      15:      taps = 16'h0003;
      16:      taps = 16'h6801;
      default: taps = 16'h0009;
    endcase
    return taps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pn_feedback.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pn_feedback                                              |
// | Description : Combinational LFSR feedback bit, XOR-reduce of the       |
// |               current state masked by the tap pattern.                 |
// | Ports       : i_state [WIDTH-1:0]  current LFSR state                  |
// |               o_fb                 feedback bit                        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module pn_feedback #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1001
) (
  input  logic [WIDTH-1:0] i_state,
  output logic             o_fb
);

  assign o_fb = ^(i_state & TAPS);

endmodule
`default_nettype wire

// File: rtl/pn_seq_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pn_seq_gen                                               |
// | Description : Fibonacci LFSR pseudo-noise generator with runtime seed  |
// |               load, all-zero lock-up recovery and epoch strobe.        |
// | Ports       : clk_mar            rising-edge clock                     |
// |               rst                async active-low reset                |
// |               en                 advance one step per clock            |
// |               load               load seed_in (priority over en)       |
// |               seed_in [WIDTH-1:0] runtime seed                         |
// |               m_data  [WIDTH-1:0] current LFSR state                   |
// |               m_out              PN bit (m_data[0])                    |
// |               m_valid            high while running                    |
// |               epoch              strobe after a full PERIOD of steps   |
// |               zero_err           strobe after all-zero recovery        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module pn_seq_gen
  import pn_pkg::*;
#(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(pn_default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
  parameter int               PERIOD = (1 << WIDTH) - 1
) (
  input  logic             clk_mar,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] m_data,
  output logic             m_out,
  output logic             m_valid,
  output logic             epoch,
  output logic             zero_err
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam logic [CW-1:0] C_LAST_STEP = CW'(PERIOD - 1);

  pn_state_e      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic           r_epoch, w_epoch_nxt;
  logic           r_zero_err, w_zero_err_nxt;
  logic           w_fb;

  pn_feedback #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_feedback (
    .i_state (r_data),
    .o_fb    (w_fb)
  );

  always_ff @(posedge clk_mar or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_data     <= '0;
      r_cnt      <= '0;
      r_epoch    <= 1'b0;
      r_zero_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_cnt      <= w_cnt_nxt;
      r_epoch    <= w_epoch_nxt;
      r_zero_err <= w_zero_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_data_nxt     = r_data;
    w_cnt_nxt      = r_cnt;
    w_epoch_nxt    = 1'b0;
    w_zero_err_nxt = 1'b0;
    case (r_state)
      ST_INIT: begin
        // Leave INIT unconditionally on the first edge after reset release.
        w_state_nxt = ST_RUN;
        w_data_nxt  = SEED;
        w_cnt_nxt   = '0;
      end
      ST_RUN: begin
        if (load) begin
          w_cnt_nxt = '0;
          if (seed_in == '0) begin
            // An all-zero seed would lock the LFSR; substitute SEED.
            w_data_nxt     = SEED;
            w_zero_err_nxt = 1'b1;
          end else begin
            w_data_nxt = seed_in;
          end
        end else if (r_data == '0) begin
          // Lock-up recovery is independent of en and never counts as a step.
          w_data_nxt     = SEED;
          w_cnt_nxt      = '0;
          w_zero_err_nxt = 1'b1;
        end else if (en) begin
          w_data_nxt = {w_fb, r_data[WIDTH-1:1]};
          if (r_cnt == C_LAST_STEP) begin
            w_cnt_nxt   = '0;
            w_epoch_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_data_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign m_data   = r_data;
  assign m_out    = r_data[0];
  assign m_valid  = (r_state == ST_RUN);
  assign epoch    = r_epoch;
  assign zero_err = r_zero_err;

endmodule
`default_nettype wire

// File: tb/tb_pn_seq_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_pn_seq_gen                                            |
// | Description : Self-checking bench for pn_seq_gen. A behavioural model  |
// |               is compared on every cycle; directed phases add literal  |
// |               expectations. A second instance with an empty tap mask   |
// |               decays to zero on its own to exercise lock-up recovery.  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_pn_seq_gen;

  logic       clk_mar;
  logic       rst, en, load;
  logic [3:0] seed_in;
  logic [3:0] m_data;
  logic       m_out, m_valid, epoch, zero_err;

  logic       rst_z;
  logic [3:0] z_data;
  logic       z_out, z_valid, z_epoch, z_zero_err;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  pn_seq_gen u_dut (
    .clk_mar  (clk_mar),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .seed_in  (seed_in),
    .m_data   (m_data),
    .m_out    (m_out),
    .m_valid  (m_valid),
    .epoch    (epoch),
    .zero_err (zero_err)
  );

  pn_seq_gen #(
    .TAPS (4'b0000)
  ) u_dut_z (
    .clk_mar  (clk_mar),
    .rst      (rst_z),
    .en       (1'b1),
    .load     (1'b0),
    .seed_in  (4'b0000),
    .m_data   (z_data),
    .m_out    (z_out),
    .m_valid  (z_valid),
    .epoch    (z_epoch),
    .zero_err (z_zero_err)
  );

  initial begin
    clk_mar = 1'b0;
    forever #5 clk_mar = ~clk_mar;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the default instance -----------
  // The sequence is x^4+x^3+1 on a right-shifting register: the new MSB is
  // the parity of bits 0 and 3. Epochs are counted as total steps since the
  // last (re)start being a multiple of 15.
  int md     = 0;
  int msteps = 0;
  bit mrun   = 0;
  bit mepoch = 0;
  bit mzerr  = 0;

  always @(posedge clk_mar or negedge rst) begin
    if (!rst) begin
      md = 0; msteps = 0; mrun = 0; mepoch = 0; mzerr = 0;
    end else begin
      mepoch = 0;
      mzerr  = 0;
      if (!mrun) begin
        mrun = 1; md = 1; msteps = 0;
      end else if (load) begin
        msteps = 0;
        if (seed_in == 0) begin
          md = 1; mzerr = 1;
        end else begin
          md = int'(seed_in);
        end
      end else if (md == 0) begin
        md = 1; msteps = 0; mzerr = 1;
      end else if (en) begin
        md = (md / 2) + 8 * ($countones(md & 9) % 2);
        msteps = msteps + 1;
        mepoch = (msteps % 15 == 0);
      end
    end
  end

  always @(negedge clk_mar) begin
    if (chk_en) begin
      check("model m_data",   int'(m_data),   md);
      check("model m_out",    int'(m_out),    md % 2);
      check("model m_valid",  int'(m_valid),  int'(mrun));
      check("model epoch",    int'(epoch),    int'(mepoch));
      check("model zero_err", int'(zero_err), int'(mzerr));
    end
  end

  // ---------------- directed phases --------------------------------------
  int exp_seq [16] = '{1, 8, 12, 14, 15, 7, 11, 5, 10, 13, 6, 3, 9, 4, 2, 1};

  initial begin
    int  pulses, first_at, second_at, found_at;
    bit  all_at_seed, found;

    rst = 1'b0; rst_z = 1'b0; en = 1'b0; load = 1'b0; seed_in = 4'b0000;
    repeat (2) @(negedge clk_mar);
    check("reset m_data",   int'(m_data),   0);
    check("reset m_valid",  int'(m_valid),  0);
    check("reset epoch",    int'(epoch),    0);
    check("reset zero_err", int'(zero_err), 0);

    // Reset release: INIT -> RUN regardless of en, then the m-sequence.
    rst = 1'b1; en = 1'b1; chk_en = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_mar);
      check("seq m_data", int'(m_data), exp_seq[i]);
      if (i == 0)  check("seq first valid", int'(m_valid), 1);
      if (i == 0)  check("seq no early epoch", int'(epoch), 0);
      if (i == 15) check("seq epoch at wrap", int'(epoch), 1);
    end

    // 30 further steps: two epochs, 15 apart, each at the seed state.
    pulses = 0; first_at = 0; second_at = 0; all_at_seed = 1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_mar);
      if (epoch) begin
        pulses++;
        if (pulses == 1) first_at = c; else second_at = c;
        if (m_data != 4'b0001) all_at_seed = 0;
      end
    end
    check("run30 epoch count",   pulses, 2);
    check("run30 epoch spacing", second_at - first_at, 15);
    check("run30 epoch at 0001", int'(all_at_seed), 1);

    // en alternating: every state held two cycles, epoch spacing 30.
    pulses = 0; first_at = 0; second_at = 0;
    for (int c = 1; c <= 60; c++) begin
      en = (c % 2 == 1);
      @(negedge clk_mar);
      if (epoch) begin
        pulses++;
        if (pulses == 1) first_at = c; else second_at = c;
      end
    end
    check("toggle epoch count",   pulses, 2);
    check("toggle first epoch",   first_at, 29);
    check("toggle epoch spacing", second_at - first_at, 30);

    // Load with en also high: load wins, counter restarts.
    en = 1'b1; load = 1'b1; seed_in = 4'b1010;
    @(negedge clk_mar);
    check("load m_data", int'(m_data), 10);
    check("load no epoch", int'(epoch), 0);
    load = 1'b0; seed_in = 4'b0000;
    found_at = 0;
    for (int k = 1; k <= 40 && found_at == 0; k++) begin
      @(negedge clk_mar);
      if (epoch) begin
        found_at = k;
        check("load epoch state", int'(m_data), 10);
      end
    end
    check("load epoch latency", found_at, 15);

    // Zero seed substitutes SEED and flags it once.
    load = 1'b1; seed_in = 4'b0000;
    @(negedge clk_mar);
    load = 1'b0;
    check("zero load m_data",   int'(m_data),   1);
    check("zero load zero_err", int'(zero_err), 1);
    @(negedge clk_mar);
    check("zero load strobe one cycle", int'(zero_err), 0);

    // Run to 1011, then reset asynchronously mid-cycle.
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_data == 4'b1011) found = 1;
      else @(negedge clk_mar);
    end
    check("reach 1011", int'(found), 1);
    #2 rst = 1'b0;
    #1;
    check("async rst m_data",   int'(m_data),   0);
    check("async rst m_out",    int'(m_out),    0);
    check("async rst m_valid",  int'(m_valid),  0);
    check("async rst epoch",    int'(epoch),    0);
    check("async rst zero_err", int'(zero_err), 0);
    @(negedge clk_mar);
    rst = 1'b1;
    @(negedge clk_mar);
    check("restart m_data",  int'(m_data),  1);
    check("restart m_valid", int'(m_valid), 1);
    @(negedge clk_mar);
    check("restart step", int'(m_data), 8);

    // Empty tap mask: 0001 shifts to 0000, which must be recovered.
    rst_z = 1'b1;
    @(negedge clk_mar);
    check("z start data",     int'(z_data),     1);
    check("z start zero_err", int'(z_zero_err), 0);
    @(negedge clk_mar);
    check("z decay data", int'(z_data), 0);
    @(negedge clk_mar);
    check("z recover data",     int'(z_data),     1);
    check("z recover zero_err", int'(z_zero_err), 1);
    check("z recover no epoch", int'(z_epoch),    0);
    @(negedge clk_mar);
    check("z strobe one cycle", int'(z_zero_err), 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pn_seq_gen.md
PN_SEQ_GEN -- requirements
Module: pn_seq_gen

Interface
REQ-001 Parameter WIDTH, default 4, LFSR length in bits, legal range 3..16.
REQ-002 Parameter TAPS, default 4'b1001 (WIDTH bits), feedback tap mask, bit i set means state bit i enters the XOR.
REQ-003 Parameter SEED, default 1 (WIDTH bits), nonzero start and recovery value.
REQ-004 Parameter PERIOD, default 2**WIDTH-1, number of steps per epoch.
REQ-005 clk_mar  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  advances the LFSR one step per clock while high.
REQ-008 load  input  1  single-cycle request to load seed_in.
REQ-009 seed_in  input  WIDTH  runtime seed value.
REQ-010 m_data  output  WIDTH  current LFSR state.
REQ-011 m_out  output  1  PN bit, equal to m_data[0].
REQ-012 m_valid  output  1  high while in RUN.
REQ-013 epoch  output  1  one-cycle strobe when a full PERIOD of steps completes.
REQ-014 zero_err  output  1  one-cycle strobe when an all-zero lock-up state is recovered.

Function
REQ-015 The block SHALL have two states, INIT and RUN; reset enters INIT.
REQ-016 INIT SHALL move to RUN on the first clock after reset release, loading m_data=SEED and step_cnt=0, whatever the value of en.
REQ-017 In RUN with en=1 and load=0, the next m_data SHALL be {fb, m_data[WIDTH-1:1]}, where fb = XOR-reduce(m_data & TAPS).
REQ-018 In RUN with en=0 and load=0, m_data and step_cnt SHALL hold.
REQ-019 In RUN, load=1 SHALL set m_data=seed_in and step_cnt=0 on the next edge, regardless of en; load has priority over en.
REQ-020 If load=1 with seed_in all-zero, the block SHALL load SEED instead and pulse zero_err the following cycle.
REQ-021 If m_data is all-zero in RUN without load, the next edge SHALL load SEED, clear step_cnt and pulse zero_err; epoch SHALL NOT pulse.
REQ-022 step_cnt (width ceil(log2(PERIOD+1))) SHALL increment on each enabled step and wrap from PERIOD-1 to 0.
REQ-023 epoch SHALL be registered and high for exactly the cycle after the step on which step_cnt wraps to 0.
REQ-024 m_out SHALL be combinationally m_data[0]; there is no further output latency beyond the state register.
REQ-025 m_valid SHALL be 0 in INIT and 1 in RUN.

Reset
REQ-026 Asserting rst low, including mid-sequence, SHALL immediately force m_data=0, step_cnt=0, epoch=0, zero_err=0, m_valid=0 and state=INIT.
REQ-027 After rst deasserts, behaviour SHALL follow REQ-016 without further stimulus.

Structure
REQ-028 The state encoding (INIT=2'b00, RUN=2'b01) and the default tap masks for WIDTH 3..16 SHALL live in a shared package, pn_pkg.
REQ-029 One sub-module is natural: pn_feedback (combinational XOR-reduce of state & TAPS); all other logic SHALL stay in pn_seq_gen.
REQ-030 With default parameters, m_data SHALL match the legacy 4-bit m-sequence generator cycle for cycle when en is tied high.

Verification
REQ-031 Release reset, en=1, defaults -> m_data: 0000, 0001, 1000, 1100, 1110, 1111, 0111, 1011, 0101, 1010, 1101, 0110, 0011, 1001, 0100, 0010, 0001 ...; m_valid rises with the first 0001.
REQ-032 en=1 for 30 steps -> epoch pulses exactly twice, each pulse coinciding with m_data=0001, separated by 15 cycles.
REQ-033 en toggled 1/0 every cycle -> each state is held for 2 cycles; epoch spacing doubles to 30 cycles.
REQ-034 load=1 with seed_in=4'b1010 and en=1 in the same cycle -> next m_data=1010, step_cnt=0; next epoch follows 15 steps later.
REQ-035 load with seed_in=0 -> m_data=0001 and zero_err pulses once; forcing m_data to 0 -> SEED is reloaded next cycle and zero_err pulses.
REQ-036 rst pulsed low mid-sequence (at m_data=1011) -> all outputs are 0 at once; after release the sequence restarts at 0001.
